// File: rtl/trdb_pkg.sv
// Shared types and defaults for the trace trigger unit.
package trdb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_REQ_ON   = 3'd2,
        ST_WAIT_ON  = 3'd3,
        ST_TRACING  = 3'd4,
        ST_REQ_OFF  = 3'd5,
        ST_WAIT_OFF = 3'd6
    } trigger_state_e;

    localparam int TRIG_REQ_HOLD_DEF    = 2;
    localparam int TRIG_ACK_TIMEOUT_DEF = 16;

endpackage

// File: rtl/trdb_addr_cmp.sv
// Retire-gated address equality compare; purely combinational.
module trdb_addr_cmp #(
    parameter int XLEN = 32
) (
    input  logic            i_retire,
    input  logic [XLEN-1:0] i_iaddr,
    input  logic [XLEN-1:0] i_addr,
    output logic            o_match
);

    assign o_match = i_retire && (i_iaddr == i_addr);

endmodule

// File: rtl/trdb_trigger.sv
// Trace trigger: raises held on/off requests to the trace control register and waits for ack.
// Optional TRDB_TRIGGER_COUNT_EN adds start_count_i (fire on the Nth start match).
module trdb_trigger
    import trdb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REQ_HOLD    = TRIG_REQ_HOLD_DEF,
    parameter int ACK_TIMEOUT = TRIG_ACK_TIMEOUT_DEF,
    parameter int CNT_W       = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            arm_i,
    input  logic            iretire_i,
    input  logic [XLEN-1:0] iaddr_i,
    input  logic [XLEN-1:0] start_addr_i,
    input  logic [XLEN-1:0] stop_addr_i,
    input  logic            trace_enable_i,
    input  logic            clr_err_i,
`ifdef TRDB_TRIGGER_COUNT_EN
    input  logic [CNT_W-1:0] start_count_i,
`endif
    output logic            trace_req_on_o,
    output logic            trace_req_off_o,
    output logic            busy_o,
    output logic            ack_timeout_o
);

    localparam int HOLD_W = (REQ_HOLD > 1) ? $clog2(REQ_HOLD + 1) : 1;
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REQ_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(ACK_TIMEOUT);

    trigger_state_e    r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [TO_W-1:0]   r_to;
    logic              r_req_on;
    logic              r_req_off;
    logic              r_busy;
    logic              r_err;

    trigger_state_e    w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [TO_W-1:0]   w_to_nxt;
    logic              w_to_set;
    logic              w_start_hit;
    logic              w_stop_hit;
    logic              w_fire;

    trdb_addr_cmp #(.XLEN(XLEN)) u_cmp_start (
        .i_retire (iretire_i),
        .i_iaddr  (iaddr_i),
        .i_addr   (start_addr_i),
        .o_match  (w_start_hit)
    );

    trdb_addr_cmp #(.XLEN(XLEN)) u_cmp_stop (
        .i_retire (iretire_i),
        .i_iaddr  (iaddr_i),
        .i_addr   (stop_addr_i),
        .o_match  (w_stop_hit)
    );

`ifdef TRDB_TRIGGER_COUNT_EN
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] w_occ_inc;
    logic [CNT_W-1:0] w_occ_tgt;

    // A requested count of zero behaves as "first match".
    assign w_occ_inc = (r_occ == '1) ? r_occ : r_occ + 1'b1;
    assign w_occ_tgt = (start_count_i == '0) ? CNT_W'(1) : start_count_i;
    assign w_fire    = w_start_hit && (w_occ_inc >= w_occ_tgt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_occ <= '0;
        end else if ((r_state == ST_IDLE && w_state_nxt == ST_ARMED) ||
                     (r_state != ST_REQ_ON && w_state_nxt == ST_REQ_ON)) begin
            r_occ <= '0;
        end else if (r_state == ST_ARMED && w_start_hit) begin
            r_occ <= w_occ_inc;
        end
    end
`else
    assign w_fire = w_start_hit;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_to_nxt    = r_to;
        w_to_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm_i) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!arm_i)      w_state_nxt = ST_IDLE;
                else if (w_fire) w_state_nxt = ST_REQ_ON;
            end
            ST_REQ_ON: begin
                if (r_hold == HOLD_LAST) w_state_nxt = ST_WAIT_ON;
                else                     w_hold_nxt  = r_hold + 1'b1;
            end
            ST_WAIT_ON: begin
                if (trace_enable_i) begin
                    w_state_nxt = ST_TRACING;
                end else if (r_to == TO_LAST) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = arm_i ? ST_ARMED : ST_IDLE;
                end else if (r_to != TO_MAX) begin
                    w_to_nxt = r_to + 1'b1;
                end
            end
            ST_TRACING: begin
                // Trace already turned off elsewhere: nothing to request.
                if (!trace_enable_i)          w_state_nxt = ST_ARMED;
                else if (w_stop_hit || !arm_i) w_state_nxt = ST_REQ_OFF;
            end
            ST_REQ_OFF: begin
                if (r_hold == HOLD_LAST) w_state_nxt = ST_WAIT_OFF;
                else                     w_hold_nxt  = r_hold + 1'b1;
            end
            ST_WAIT_OFF: begin
                if (!trace_enable_i) begin
                    w_state_nxt = arm_i ? ST_ARMED : ST_IDLE;
                end else if (r_to == TO_LAST) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = arm_i ? ST_ARMED : ST_IDLE;
                end else if (r_to != TO_MAX) begin
                    w_to_nxt = r_to + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_state_nxt != r_state) begin
            if (w_state_nxt == ST_REQ_ON || w_state_nxt == ST_REQ_OFF)
                w_hold_nxt = '0;
            if (w_state_nxt == ST_WAIT_ON || w_state_nxt == ST_WAIT_OFF)
                w_to_nxt = '0;
        end
    end

    // Outputs are flopped from the next-state decode so they line up with the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_hold    <= '0;
            r_to      <= '0;
            r_req_on  <= 1'b0;
            r_req_off <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_to      <= w_to_nxt;
            r_req_on  <= (w_state_nxt == ST_REQ_ON);
            r_req_off <= (w_state_nxt == ST_REQ_OFF);
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (w_to_set)       r_err <= 1'b1;
            else if (clr_err_i) r_err <= 1'b0;
        end
    end

    assign trace_req_on_o  = r_req_on;
    assign trace_req_off_o = r_req_off;
    assign busy_o          = r_busy;
    assign ack_timeout_o   = r_err;

endmodule

// File: tb/tb_trdb_trigger.sv
// Directed self-checking bench for trdb_trigger (default build; count tests under the macro).
module tb_trdb_trigger;

    localparam logic [31:0] START = 32'h8000_0100;
    localparam logic [31:0] STOP  = 32'h8000_0200;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        arm_i = 1'b0;
    logic        iretire_i = 1'b0;
    logic [31:0] iaddr_i = '0;
    logic [31:0] start_addr_i = START;
    logic [31:0] stop_addr_i = STOP;
    logic        trace_enable_i = 1'b0;
    logic        clr_err_i = 1'b0;
`ifdef TRDB_TRIGGER_COUNT_EN
    logic [7:0]  start_count_i = 8'd0;
`endif
    logic        trace_req_on_o;
    logic        trace_req_off_o;
    logic        busy_o;
    logic        ack_timeout_o;

    int n_chk = 0;
    int n_fail = 0;

    trdb_trigger dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .arm_i           (arm_i),
        .iretire_i       (iretire_i),
        .iaddr_i         (iaddr_i),
        .start_addr_i    (start_addr_i),
        .stop_addr_i     (stop_addr_i),
        .trace_enable_i  (trace_enable_i),
        .clr_err_i       (clr_err_i),
`ifdef TRDB_TRIGGER_COUNT_EN
        .start_count_i   (start_count_i),
`endif
        .trace_req_on_o  (trace_req_on_o),
        .trace_req_off_o (trace_req_off_o),
        .busy_o          (busy_o),
        .ack_timeout_o   (ack_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", tag, act, exp);
        end
    endtask

    // outputs packed as {on, off, busy, err}
    function automatic logic [3:0] outs();
        return {trace_req_on_o, trace_req_off_o, busy_o, ack_timeout_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic retire(input logic [31:0] a);
        iretire_i = 1'b1;
        iaddr_i   = a;
        step();
        iretire_i = 1'b0;
        iaddr_i   = '0;
    endtask

    initial begin
        // reset with arm held high
        arm_i = 1'b1;
        rst_i = 1'b1;
        step(); step();
        chk("reset", outs(), 4'b0000);
        rst_i = 1'b0;
        step();
        chk("armed_after_rst", outs(), 4'b0010);

        // stop address ignored while armed
        retire(STOP);
        chk("armed_ignores_stop", outs(), 4'b0010);

        // on request: high for two cycles after the retire
        retire(START);
        chk("on_t1", outs(), 4'b1010);
        step();
        chk("on_t2", outs(), 4'b1010);
        step();
        chk("on_drop", outs(), 4'b0010);
        trace_enable_i = 1'b1;
        step();
        chk("tracing", outs(), 4'b0010);
        retire(START);
        chk("tracing_ignores_start", outs(), 4'b0010);
        retire(STOP);
        chk("off_t1", outs(), 4'b0110);
        step();
        chk("off_t2", outs(), 4'b0110);
        step();
        chk("off_drop", outs(), 4'b0010);
        trace_enable_i = 1'b0;
        step();
        chk("back_armed", outs(), 4'b0010);

        // timeout: no ack after the on request
        retire(START);
        chk("to_on", outs(), 4'b1010);
        step(); step();
        chk("to_wait", outs(), 4'b0010);
        for (int i = 0; i < 15; i++) step();
        chk("to_not_yet", outs(), 4'b0010);
        clr_err_i = 1'b1;  // set must win over clear on the same edge
        step();
        chk("to_set_wins", outs(), 4'b0011);
        step();
        chk("to_cleared", outs(), 4'b0010);
        clr_err_i = 1'b0;

        // still armed: a new start match fires
        retire(START);
        chk("rearm_on", outs(), 4'b1010);
        step(); step();
        trace_enable_i = 1'b1;
        step();
        chk("tracing2", outs(), 4'b0010);

        // disarm in tracing: off request without an address match
        arm_i = 1'b0;
        step();
        chk("disarm_off1", outs(), 4'b0110);
        step();
        chk("disarm_off2", outs(), 4'b0110);
        step();
        chk("disarm_wait", outs(), 4'b0010);
        trace_enable_i = 1'b0;
        step();
        chk("disarm_idle", outs(), 4'b0000);

        // external turn-off in tracing
        arm_i = 1'b1;
        step();
        retire(START);
        step(); step();
        trace_enable_i = 1'b1;
        step();
        trace_enable_i = 1'b0;
        step();
        chk("ext_off_armed", outs(), 4'b0010);
        step();
        chk("ext_off_noreq", outs(), 4'b0010);
        retire(START);
        chk("ext_off_new_on", outs(), 4'b1010);

        // reset in the middle of a request
        rst_i = 1'b1;
        step();
        chk("rst_mid_req", outs(), 4'b0000);
        rst_i = 1'b0;
        step();
        chk("rst_rearm", outs(), 4'b0010);

`ifdef TRDB_TRIGGER_COUNT_EN
        start_count_i = 8'd3;
        retire(START);
        chk("cnt_first", outs(), 4'b0010);
        step();
        retire(START);
        chk("cnt_second", outs(), 4'b0010);
        retire(START);
        chk("cnt_third", outs(), 4'b1010);
        rst_i = 1'b1;
        step();
        chk("cnt_rst_req", outs(), 4'b0000);
        rst_i = 1'b0;
        start_count_i = 8'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
